ram1_port_arbiter: RTL

- Shares the two-port 32x32 RAM (write port 0, read port 1) between two requesters, e.g. a writeback path and a load/debug path.
- Each requester issues one read or write per valid/ready handshake.
- The arbiter owns every RAM control pin and registers read data back to the requester.
- After reset it runs a clear sequence that zeroes every RAM entry before accepting traffic.

---
 rtl/ram1_port_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/ram1_port_arbiter.sv
// Two-requester arbiter for a 1W/1R RAM. Clears the RAM after reset, then grants reads and writes independently.
// Latency: ready is combinational, read data arrives 1 cycle after the handshake. Optional WR_BYPASS_EN forwards same-cycle write data.
module ram1_port_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic              r0_wr,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic              r1_wr,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              init_done,
    output logic              ram_we,
    output logic              ram_prt_en0,
    output logic [DATA_W-1:0] ram_data_0,
    output logic [ADDR_W-1:0] ram_address_0,
    output logic              ram_re,
    output logic              ram_prt_en1,
    output logic [ADDR_W-1:0] ram_address_1,
    input  logic [DATA_W-1:0] ram_data_1
);
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] init_cnt;
    logic              wr_ptr;
    logic              rd_ptr;
    logic              run;
    logic              wc0, wc1, rc0, rc1;
    logic              wg0, wg1, rg0, rg1;
    logic [DATA_W-1:0] rd_val;

    assign run       = (state == ST_RUN);
    assign init_done = run;

    assign wc0 = run & r0_valid & r0_wr;
    assign wc1 = run & r1_valid & r1_wr;
    assign rc0 = run & r0_valid & ~r0_wr;
    assign rc1 = run & r1_valid & ~r1_wr;

    // Contention resolved by the pointer; a lone candidate always wins.
    assign wg0 = wc0 & (~wc1 | (wr_ptr == 1'b0));
    assign wg1 = wc1 & (~wc0 | (wr_ptr == 1'b1));
    assign rg0 = rc0 & (~rc1 | (rd_ptr == 1'b0));
    assign rg1 = rc1 & (~rc0 | (rd_ptr == 1'b1));

    assign r0_ready = wg0 | rg0;
    assign r1_ready = wg1 | rg1;

    always_comb begin
        ram_we        = 1'b0;
        ram_prt_en0   = 1'b0;
        ram_data_0    = '0;
        ram_address_0 = '0;
        ram_re        = 1'b0;
        ram_prt_en1   = 1'b0;
        ram_address_1 = '0;
        if (!run) begin
            ram_we        = 1'b1;
            ram_prt_en0   = 1'b1;
            ram_address_0 = init_cnt;
        end else begin
            if (wg0 | wg1) begin
                ram_we        = 1'b1;
                ram_prt_en0   = 1'b1;
                ram_address_0 = wg0 ? r0_addr : r1_addr;
                ram_data_0    = wg0 ? r0_wdata : r1_wdata;
            end
            if (rg0 | rg1) begin
                ram_re        = 1'b1;
                ram_prt_en1   = 1'b1;
                ram_address_1 = rg0 ? r0_addr : r1_addr;
            end
        end
    end

`ifdef WR_BYPASS_EN
    assign rd_val = (run && (wg0 | wg1) && (ram_address_0 == ram_address_1)) ? ram_data_0 : ram_data_1;
`else
    assign rd_val = ram_data_1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            r0_rvalid <= 1'b0;
            r1_rvalid <= 1'b0;
            r0_rdata  <= '0;
            r1_rdata  <= '0;
        end else begin
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + 1'b1;
                if (init_cnt == LAST_ADDR)
                    state <= ST_RUN;
            end
            if (wg0) wr_ptr <= 1'b1;
            if (wg1) wr_ptr <= 1'b0;
            if (rg0) rd_ptr <= 1'b1;
            if (rg1) rd_ptr <= 1'b0;
            r0_rvalid <= rg0;
            r1_rvalid <= rg1;
            if (rg0) r0_rdata <= rd_val;
            if (rg1) r1_rdata <= rd_val;
        end
    end
endmodule
